// File: rtl/fpl_pkg.sv
// Shared constants and helpers for the free-page list.
package fpl_pkg;

  localparam int FPL_NUM_PAGES = 2048;
  localparam int FPL_LOW_WM    = 16;

  // Page address width; at least 1 bit so a 2-page pool still has an address.
  function automatic int calc_addr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int FPL_ADDR_W = calc_addr_w(FPL_NUM_PAGES);

  typedef logic [FPL_ADDR_W-1:0] page_addr_t;

  // Increment with explicit wrap so non-power-of-2 depths work.
  function automatic int unsigned ptr_wrap(input int unsigned ptr, input int unsigned depth);
    return (ptr + 32'd1 >= depth) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fpl_ring_ram.sv
// Ring storage for returned pages: one write port, combinational read port.
module fpl_ring_ram #(
  parameter int DEPTH = 2048,
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             we,
  input  logic [WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/free_page_list.sv
// Free-page manager: lazy counter init, then a ring of returned pages.
// Optional double-free/range checking is enabled by FREE_PAGE_LIST_DFREE_CHECK_EN.
module free_page_list
  import fpl_pkg::*;
#(
  parameter int NUM_PAGES = FPL_NUM_PAGES,
  parameter int ADDR_W    = calc_addr_w(NUM_PAGES),
  parameter int LOW_WM    = FPL_LOW_WM
) (
  input  logic              clk,
  input  logic              rst,
  output logic              alloc_valid,
  input  logic              alloc_ready,
  output logic [ADDR_W-1:0] alloc_addr,
  input  logic              free_valid,
  input  logic [ADDR_W-1:0] free_addr,
  output logic [ADDR_W:0]   free_cnt,
  output logic              almost_empty,
  output logic              init_done,
  output logic              err_overflow,
  output logic              err_dfree
);

  localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W+1)'(NUM_PAGES);
  localparam logic [ADDR_W:0]   CNT_LOW   = (ADDR_W+1)'(LOW_WM);
  localparam logic [ADDR_W-1:0] LAST_PAGE = ADDR_W'(NUM_PAGES - 1);

  logic [ADDR_W-1:0] init_cnt;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] ring_rdata;
  logic [ADDR_W:0]   cnt_next;
  logic              fire;
  logic              full;
  logic              dfree_bad;
  logic              push_ok;
  logic              push_ovf;
  logic              init_done_next;

  assign alloc_valid = (free_cnt != '0);
  // Counter is the source until exhausted; pages pushed meanwhile wait in the ring.
  assign alloc_addr  = init_done ? ring_rdata : init_cnt;
  assign fire        = alloc_valid & alloc_ready;
  assign full        = (free_cnt == CNT_FULL);

  assign push_ok  = free_valid & ~dfree_bad & (~full | fire);
  assign push_ovf = free_valid & ~dfree_bad & full & ~fire;

  assign init_done_next = init_done | (fire & ~init_done & (init_cnt == LAST_PAGE));

  always_comb begin
    cnt_next = free_cnt;
    if (push_ok && !fire)      cnt_next = free_cnt + (ADDR_W+1)'(1);
    else if (fire && !push_ok) cnt_next = free_cnt - (ADDR_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt     <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      free_cnt     <= CNT_FULL;
      init_done    <= 1'b0;
      almost_empty <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (fire && !init_done) init_cnt <= init_cnt + ADDR_W'(1);
      if (fire && init_done)  rd_ptr   <= ADDR_W'(ptr_wrap(32'(rd_ptr), NUM_PAGES));
      if (push_ok)            wr_ptr   <= ADDR_W'(ptr_wrap(32'(wr_ptr), NUM_PAGES));
      free_cnt     <= cnt_next;
      init_done    <= init_done_next;
      almost_empty <= (cnt_next <= CNT_LOW);
      err_overflow <= push_ovf;
    end
  end

`ifdef FREE_PAGE_LIST_DFREE_CHECK_EN
  // Bit set = page is out with a consumer; pages not yet issued by the counter read as free.
  logic [NUM_PAGES-1:0] owned;
  logic                 in_range;

  assign in_range  = ({1'b0, free_addr} < CNT_FULL);
  assign dfree_bad = free_valid & (~in_range | ~owned[free_addr]);

  always_ff @(posedge clk) begin
    if (rst) begin
      owned     <= '0;
      err_dfree <= 1'b0;
    end else begin
      if (fire)    owned[alloc_addr] <= 1'b1;
      if (push_ok) owned[free_addr]  <= 1'b0;
      err_dfree <= dfree_bad;
    end
  end
`else
  assign dfree_bad = 1'b0;
  assign err_dfree = 1'b0;
`endif

  fpl_ring_ram #(
    .DEPTH (NUM_PAGES),
    .WIDTH (ADDR_W)
  ) u_ring (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (free_addr),
    .raddr (rd_ptr),
    .rdata (ring_rdata)
  );

endmodule

// File: tb/tb_free_page_list.sv
// Directed bench for free_page_list (2048 pages, low watermark 16).
module tb_free_page_list;

  localparam int N  = 2048;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alloc_ready = 1'b0;
  logic          free_valid = 1'b0;
  logic [AW-1:0] free_addr = '0;
  logic          alloc_valid;
  logic [AW-1:0] alloc_addr;
  logic [AW:0]   free_cnt;
  logic          almost_empty;
  logic          init_done;
  logic          err_overflow;
  logic          err_dfree;

  int n_checks = 0;
  int n_fail   = 0;

  free_page_list #(
    .NUM_PAGES (N),
    .ADDR_W    (AW),
    .LOW_WM    (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_valid  (alloc_valid),
    .alloc_ready  (alloc_ready),
    .alloc_addr   (alloc_addr),
    .free_valid   (free_valid),
    .free_addr    (free_addr),
    .free_cnt     (free_cnt),
    .almost_empty (almost_empty),
    .init_done    (init_done),
    .err_overflow (err_overflow),
    .err_dfree    (err_dfree)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    alloc_ready = 1'b0;
    free_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    n_checks++;
    if ({alloc_valid, alloc_addr, free_cnt} !== {1'b1, 11'd0, 12'd2048}) begin
      n_fail++;
      $display("FAIL reset_alloc: got valid=%0d addr=%0d cnt=%0d want 1/0/2048", alloc_valid, alloc_addr, free_cnt);
    end
    n_checks++;
    if ({init_done, almost_empty, err_overflow, err_dfree} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000", {init_done, almost_empty, err_overflow, err_dfree});
    end
    // traffic, then reset in the middle of a push+pop cycle
    rst = 1'b0;
    alloc_ready = 1'b1;
    step();
    step();
    n_checks++;
    if (alloc_addr !== 11'd2) begin
      n_fail++;
      $display("FAIL pre_reset_addr: got %0d want 2", alloc_addr);
    end
    rst = 1'b1;
    free_valid = 1'b1;
    free_addr = 11'd1;
    step();
    n_checks++;
    if ({alloc_valid, alloc_addr, free_cnt, err_overflow} !== {1'b1, 11'd0, 12'd2048, 1'b0}) begin
      n_fail++;
      $display("FAIL midop_reset: got valid=%0d addr=%0d cnt=%0d ovf=%0d want 1/0/2048/0", alloc_valid, alloc_addr, free_cnt, err_overflow);
    end
    free_valid = 1'b0;
    alloc_ready = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_init_drain();
    do_reset();
    alloc_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (alloc_valid !== 1'b1 || alloc_addr !== AW'(i)) begin
        n_fail++;
        $display("FAIL init_issue[%0d]: got valid=%0d addr=%0d want 1/%0d", i, alloc_valid, alloc_addr, i);
      end
      n_checks++;
      if (almost_empty !== ((N - i) <= 16) || init_done !== 1'b0) begin
        n_fail++;
        $display("FAIL init_flags[%0d]: got ae=%0d done=%0d want %0d/0", i, almost_empty, init_done, ((N - i) <= 16));
      end
      step();
    end
    n_checks++;
    if ({init_done, free_cnt, alloc_valid, almost_empty} !== {1'b1, 12'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL init_end: got done=%0d cnt=%0d valid=%0d ae=%0d want 1/0/0/1", init_done, free_cnt, alloc_valid, almost_empty);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (alloc_valid !== 1'b0 || free_cnt !== 12'd0) begin
        n_fail++;
        $display("FAIL empty_hold[%0d]: got valid=%0d cnt=%0d want 0/0", i, alloc_valid, free_cnt);
      end
    end
    alloc_ready = 1'b0;
  endtask

  task automatic test_push_empty();
    free_valid = 1'b1;
    free_addr = 11'h155;
    alloc_ready = 1'b1;
    #1;
    n_checks++;
    if (alloc_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL push_same_cycle: got valid=%0d want 0", alloc_valid);
    end
    step();
    free_valid = 1'b0;
    alloc_ready = 1'b0;
    n_checks++;
    if ({alloc_valid, alloc_addr, free_cnt} !== {1'b1, 11'h155, 12'd1}) begin
      n_fail++;
      $display("FAIL push_empty: got valid=%0d addr=%h cnt=%0d want 1/155/1", alloc_valid, alloc_addr, free_cnt);
    end
  endtask

  task automatic test_fifo_order();
    alloc_ready = 1'b1;
    step();
    alloc_ready = 1'b0;
    free_valid = 1'b1;
    free_addr = 11'd5;
    step();
    free_addr = 11'd9;
    step();
    free_valid = 1'b0;
    n_checks++;
    if ({free_cnt, almost_empty, alloc_addr} !== {12'd2, 1'b1, 11'd5}) begin
      n_fail++;
      $display("FAIL fifo_first: got cnt=%0d ae=%0d addr=%0d want 2/1/5", free_cnt, almost_empty, alloc_addr);
    end
    alloc_ready = 1'b1;
    step();
    n_checks++;
    if ({free_cnt, almost_empty, alloc_addr} !== {12'd1, 1'b1, 11'd9}) begin
      n_fail++;
      $display("FAIL fifo_second: got cnt=%0d ae=%0d addr=%0d want 1/1/9", free_cnt, almost_empty, alloc_addr);
    end
    step();
    alloc_ready = 1'b0;
    n_checks++;
    if ({free_cnt, almost_empty, alloc_valid} !== {12'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL fifo_drained: got cnt=%0d ae=%0d valid=%0d want 0/1/0", free_cnt, almost_empty, alloc_valid);
    end
  endtask

`ifndef FREE_PAGE_LIST_DFREE_CHECK_EN
  task automatic test_overflow();
    do_reset();
    free_valid = 1'b1;
    free_addr = 11'd7;
    step();
    free_valid = 1'b0;
    n_checks++;
    if (err_overflow !== 1'b1 || free_cnt !== 12'd2048) begin
      n_fail++;
      $display("FAIL overflow_drop: got ovf=%0d cnt=%0d want 1/2048", err_overflow, free_cnt);
    end
    step();
    n_checks++;
    if (err_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_pulse: got ovf=%0d want 0", err_overflow);
    end
    free_valid = 1'b1;
    alloc_ready = 1'b1;
    step();
    free_valid = 1'b0;
    alloc_ready = 1'b0;
    n_checks++;
    if ({err_overflow, free_cnt, alloc_addr} !== {1'b0, 12'd2048, 11'd1}) begin
      n_fail++;
      $display("FAIL overflow_with_alloc: got ovf=%0d cnt=%0d addr=%0d want 0/2048/1", err_overflow, free_cnt, alloc_addr);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr;
    do_reset();
    alloc_ready = 1'b1;
    repeat (N - 100) step();
    alloc_ready = 1'b0;
    n_checks++;
    if ({free_cnt, almost_empty, alloc_addr} !== {12'd100, 1'b0, 11'd1948}) begin
      n_fail++;
      $display("FAIL b2b_start: got cnt=%0d ae=%0d addr=%0d want 100/0/1948", free_cnt, almost_empty, alloc_addr);
    end
    for (int p = N - 100; p < N; p++) exp_q.push_back(AW'(p));
    for (int c = 0; c < 5000; c++) begin
      free_valid = 1'b1;
      free_addr = AW'($urandom_range(0, N - 1));
      alloc_ready = 1'b1;
      exp_addr = exp_q.pop_front();
      exp_q.push_back(free_addr);
      n_checks++;
      if (alloc_valid !== 1'b1 || alloc_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL b2b_order[%0d]: got valid=%0d addr=%0d want 1/%0d", c, alloc_valid, alloc_addr, exp_addr);
      end
      step();
      n_checks++;
      if (free_cnt !== 12'd100) begin
        n_fail++;
        $display("FAIL b2b_count[%0d]: got %0d want 100", c, free_cnt);
      end
    end
    free_valid = 1'b0;
    alloc_ready = 1'b0;
  endtask
`else
  task automatic test_dfree();
    do_reset();
    alloc_ready = 1'b1;
    step();
    alloc_ready = 1'b0;
    free_valid = 1'b1;
    free_addr = 11'd0;
    step();
    n_checks++;
    if (err_dfree !== 1'b0 || free_cnt !== 12'd2048) begin
      n_fail++;
      $display("FAIL dfree_first: got err=%0d cnt=%0d want 0/2048", err_dfree, free_cnt);
    end
    step();
    n_checks++;
    if (err_dfree !== 1'b1 || free_cnt !== 12'd2048) begin
      n_fail++;
      $display("FAIL dfree_second: got err=%0d cnt=%0d want 1/2048", err_dfree, free_cnt);
    end
    free_addr = 11'd5;
    step();
    free_valid = 1'b0;
    n_checks++;
    if (err_dfree !== 1'b1 || free_cnt !== 12'd2048) begin
      n_fail++;
      $display("FAIL dfree_unissued: got err=%0d cnt=%0d want 1/2048", err_dfree, free_cnt);
    end
    step();
    n_checks++;
    if (err_dfree !== 1'b0) begin
      n_fail++;
      $display("FAIL dfree_pulse: got err=%0d want 0", err_dfree);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_init_drain();
    test_push_empty();
    test_fifo_order();
`ifndef FREE_PAGE_LIST_DFREE_CHECK_EN
    test_overflow();
    test_back_to_back();
`else
    test_dfree();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
